// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS output shaping stage.
package dds_pkg;
  localparam logic [2:0]  MODE_OFF    = 3'd0;
  localparam logic [2:0]  MODE_SQUARE = 3'd4;
  localparam int          SAMPLE_FRAC = 29;
  localparam int          AMP_FRAC    = 15;
  localparam logic [31:0] ONE_Q329    = 32'h2000_0000;
  localparam int          PROD_W      = 49;

  typedef enum logic [1:0] {
    SHAPE_OFF    = 2'd0,
    SHAPE_SINE   = 2'd1,
    SHAPE_SQUARE = 2'd2
  } shape_e;

  typedef struct packed {
    logic [2:0]  mode;
    logic [15:0] amp;
    logic [15:0] offset;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{mode: MODE_OFF, amp: 16'h8000, offset: 16'h0000};

  function automatic shape_e decode_mode(input logic [2:0] mode);
    if (mode == MODE_OFF) return SHAPE_OFF;
    if (mode == MODE_SQUARE) return SHAPE_SQUARE;
    return SHAPE_SINE;
  endfunction
endpackage

// File: rtl/dds_sat_add.sv
// Midscale + signed value + signed offset, saturated to an unsigned DAC code.
module dds_sat_add #(
  parameter int DAC_W = 14,
  parameter int IN_W  = 49
) (
  input  logic [IN_W-1:0]  scaled,
  input  logic [15:0]      offset,
  output logic [DAC_W-1:0] code,
  output logic             clip
);
  localparam int SUM_W = IN_W + 3;
  localparam logic [SUM_W-1:0] MID  = SUM_W'(1) << (DAC_W - 1);
  localparam logic [SUM_W-1:0] MAXC = (SUM_W'(1) << DAC_W) - SUM_W'(1);

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum  = $signed(MID)
         + $signed({{3{scaled[IN_W-1]}}, scaled})
         + $signed({{(SUM_W-16){offset[15]}}, offset});
    code = sum[DAC_W-1:0];
    clip = 1'b0;
    if (sum[SUM_W-1]) begin
      code = '0;
      clip = 1'b1;
    end else if (sum > $signed(MAXC)) begin
      code = '1;
      clip = 1'b1;
    end
  end
endmodule

// File: rtl/dds_output_shaper.sv
// Shapes oscillator samples into DAC codes: mode select, gain, offset, saturation,
// with configuration changes deferred to a rising zero crossing.
module dds_output_shaper
  import dds_pkg::*;
#(
  parameter int          DAC_W = 14,
  parameter logic [31:0] HYST  = 32'h0010_0000
) (
  input  logic             Fg_CLK,
  input  logic             RESETn,
  input  logic             Enable,
  input  logic [31:0]      Sample,
  input  logic [2:0]       CfgMode,
  input  logic [15:0]      CfgAmp,
  input  logic [15:0]      CfgOffset,
  input  logic             CfgLoad,
  input  logic             ClipClr,
  output logic [DAC_W-1:0] DacData,
  output logic             DacValid,
  output logic             SquareOut,
  output logic             ZeroCross,
  output logic             CfgPending,
  output logic             ClipFlag
);
  localparam int SHIFT = SAMPLE_FRAC + AMP_FRAC - (DAC_W - 1);
  localparam logic [DAC_W-1:0]  DAC_MID  = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic signed [31:0] HYST_POS = $signed(HYST);
  localparam logic signed [31:0] HYST_NEG = -HYST_POS;

  cfg_t active_q, active_d, shadow_q, shadow_d;
  logic pending_q, pending_d, prev_neg_q, prev_neg_d;
  logic square_q, square_d, zero_cross_q, zero_cross_d;
  logic zc_hit, commit;

  logic                     s1_valid_q, s1_valid_d, s1_sq_q, s1_sq_d;
  logic [31:0]              s1_sample_q, s1_sample_d;
  shape_e                   s1_shape_q, s1_shape_d;
  logic [15:0]              s1_amp_q, s1_amp_d, s1_offset_q, s1_offset_d;

  logic                     s2_valid_q, s2_valid_d;
  shape_e                   s2_shape_q, s2_shape_d;
  logic [15:0]              s2_offset_q, s2_offset_d;
  logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d, s2_sqa_q, s2_sqa_d;
  logic [PROD_W-1:0]        amp_ext, sq_mag;

  logic                     s3_valid_q, s3_valid_d;
  shape_e                   s3_shape_q, s3_shape_d;
  logic [15:0]              s3_offset_q, s3_offset_d;
  logic signed [PROD_W-1:0] s3_scaled_q, s3_scaled_d, s3_sqa_q, s3_sqa_d;

  logic [DAC_W-1:0] dac_q, dac_d, sine_code, sq_code;
  logic             dac_valid_q, dac_valid_d, clip_flag_q, clip_flag_d;
  logic             sine_clip, sq_clip;

  // S1: capture sample, comparator, zero crossing and configuration commit.
  // The captured sample carries the active config from before any commit.
  always_comb begin
    zc_hit       = Enable && prev_neg_q && !Sample[31];
    commit       = pending_q && ((active_q.mode == MODE_OFF) || zc_hit);
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (CfgLoad) begin
      shadow_d  = '{mode: CfgMode, amp: CfgAmp, offset: CfgOffset};
      pending_d = 1'b1;
    end
    zero_cross_d = zc_hit;
    prev_neg_d   = prev_neg_q;
    square_d     = square_q;
    s1_valid_d   = Enable;
    s1_sample_d  = s1_sample_q;
    s1_shape_d   = s1_shape_q;
    s1_amp_d     = s1_amp_q;
    s1_offset_d  = s1_offset_q;
    s1_sq_d      = s1_sq_q;
    if (Enable) begin
      prev_neg_d = Sample[31];
      if ($signed(Sample) > HYST_POS) square_d = 1'b1;
      else if ($signed(Sample) < HYST_NEG) square_d = 1'b0;
      s1_sample_d = Sample;
      s1_shape_d  = decode_mode(active_q.mode);
      s1_amp_d    = active_q.amp;
      s1_offset_d = active_q.offset;
      s1_sq_d     = square_d;
    end
  end

  // S2: full-precision product and the signed square amplitude.
  always_comb begin
    amp_ext     = {{(PROD_W-16){1'b0}}, s1_amp_q};
    sq_mag      = (amp_ext << (DAC_W - 1)) >> AMP_FRAC;
    s2_valid_d  = s1_valid_q;
    s2_shape_d  = s1_shape_q;
    s2_offset_d = s1_offset_q;
    s2_prod_d   = $signed({{(PROD_W-32){s1_sample_q[31]}}, s1_sample_q})
                * $signed(amp_ext);
    s2_sqa_d    = s1_sq_q ? $signed(sq_mag) : -$signed(sq_mag);
  end

  // S3: rescale to DAC LSBs; the register after the multiply keeps it off the add path.
  always_comb begin
    s3_valid_d  = s2_valid_q;
    s3_shape_d  = s2_shape_q;
    s3_offset_d = s2_offset_q;
    s3_scaled_d = s2_prod_q >>> SHIFT;
    s3_sqa_d    = s2_sqa_q;
  end

  dds_sat_add #(.DAC_W(DAC_W), .IN_W(PROD_W)) u_sat_sine (
    .scaled (s3_scaled_q),
    .offset (s3_offset_q),
    .code   (sine_code),
    .clip   (sine_clip)
  );

  dds_sat_add #(.DAC_W(DAC_W), .IN_W(PROD_W)) u_sat_square (
    .scaled (s3_sqa_q),
    .offset (s3_offset_q),
    .code   (sq_code),
    .clip   (sq_clip)
  );

  // A clip on the same edge as ClipClr leaves the flag set.
  always_comb begin
    dac_d       = dac_q;
    dac_valid_d = s3_valid_q;
    clip_flag_d = clip_flag_q;
    if (ClipClr) clip_flag_d = 1'b0;
    if (s3_valid_q) begin
      case (s3_shape_q)
        SHAPE_SQUARE: begin
          dac_d       = sq_code;
          clip_flag_d = clip_flag_d | sq_clip;
        end
        SHAPE_SINE: begin
          dac_d       = sine_code;
          clip_flag_d = clip_flag_d | sine_clip;
        end
        default: dac_d = DAC_MID;
      endcase
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      active_q     <= CFG_RESET;
      shadow_q     <= CFG_RESET;
      pending_q    <= 1'b0;
      prev_neg_q   <= 1'b0;
      square_q     <= 1'b0;
      zero_cross_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sample_q  <= '0;
      s1_shape_q   <= SHAPE_OFF;
      s1_amp_q     <= 16'h8000;
      s1_offset_q  <= '0;
      s1_sq_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_shape_q   <= SHAPE_OFF;
      s2_offset_q  <= '0;
      s2_prod_q    <= '0;
      s2_sqa_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_shape_q   <= SHAPE_OFF;
      s3_offset_q  <= '0;
      s3_scaled_q  <= '0;
      s3_sqa_q     <= '0;
      dac_q        <= DAC_MID;
      dac_valid_q  <= 1'b0;
      clip_flag_q  <= 1'b0;
    end else begin
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      prev_neg_q   <= prev_neg_d;
      square_q     <= square_d;
      zero_cross_q <= zero_cross_d;
      s1_valid_q   <= s1_valid_d;
      s1_sample_q  <= s1_sample_d;
      s1_shape_q   <= s1_shape_d;
      s1_amp_q     <= s1_amp_d;
      s1_offset_q  <= s1_offset_d;
      s1_sq_q      <= s1_sq_d;
      s2_valid_q   <= s2_valid_d;
      s2_shape_q   <= s2_shape_d;
      s2_offset_q  <= s2_offset_d;
      s2_prod_q    <= s2_prod_d;
      s2_sqa_q     <= s2_sqa_d;
      s3_valid_q   <= s3_valid_d;
      s3_shape_q   <= s3_shape_d;
      s3_offset_q  <= s3_offset_d;
      s3_scaled_q  <= s3_scaled_d;
      s3_sqa_q     <= s3_sqa_d;
      dac_q        <= dac_d;
      dac_valid_q  <= dac_valid_d;
      clip_flag_q  <= clip_flag_d;
    end
  end

  assign DacData    = dac_q;
  assign DacValid   = dac_valid_q;
  assign SquareOut  = square_q;
  assign ZeroCross  = zero_cross_q;
  assign CfgPending = pending_q;
  assign ClipFlag   = clip_flag_q;
endmodule

// File: tb/tb_dds_output_shaper.sv
// Scoreboard bench for dds_output_shaper: expected DAC codes queued per Enable, checked on DacValid.
`timescale 1ns/1ps
module tb_dds_output_shaper;
  import dds_pkg::*;

  localparam int          DAC_W = 14;
  localparam logic [31:0] HYST  = 32'h0010_0000;

  logic             Fg_CLK = 1'b0;
  logic             RESETn = 1'b0;
  logic             Enable = 1'b0;
  logic [31:0]      Sample = '0;
  logic [2:0]       CfgMode = '0;
  logic [15:0]      CfgAmp = 16'h8000;
  logic [15:0]      CfgOffset = '0;
  logic             CfgLoad = 1'b0;
  logic             ClipClr = 1'b0;
  logic [DAC_W-1:0] DacData;
  logic             DacValid, SquareOut, ZeroCross, CfgPending, ClipFlag;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int mon_exp;

  dds_output_shaper #(.DAC_W(DAC_W), .HYST(HYST)) dut (
    .Fg_CLK    (Fg_CLK),
    .RESETn    (RESETn),
    .Enable    (Enable),
    .Sample    (Sample),
    .CfgMode   (CfgMode),
    .CfgAmp    (CfgAmp),
    .CfgOffset (CfgOffset),
    .CfgLoad   (CfgLoad),
    .ClipClr   (ClipClr),
    .DacData   (DacData),
    .DacValid  (DacValid),
    .SquareOut (SquareOut),
    .ZeroCross (ZeroCross),
    .CfgPending(CfgPending),
    .ClipFlag  (ClipFlag)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  always @(negedge Fg_CLK) begin
    if (DacValid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL dac_unexpected: DacValid with DacData=%0d, required no output", DacData);
      end else begin
        mon_exp = exp_q.pop_front();
        if (DacData !== DAC_W'(mon_exp)) begin
          n_bad++;
          $display("FAIL dac_data: got %0d, required %0d", DacData, mon_exp);
        end else begin
          $display("dac_out %0d expected %0d", DacData, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input int e);
    Sample = s;
    Enable = 1'b1;
    exp_q.push_back(e);
    cycle();
    Enable = 1'b0;
  endtask

  task automatic load(input logic [2:0] m, input logic [15:0] a, input logic [15:0] o);
    CfgMode   = m;
    CfgAmp    = a;
    CfgOffset = o;
    CfgLoad   = 1'b1;
    cycle();
    CfgLoad   = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 12;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    Enable  = 1'b0;
    CfgLoad = 1'b0;
    ClipClr = 1'b0;
    RESETn  = 1'b0;
    cycle();
    RESETn  = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    cycle();
    cycle();
    n_cmp++; if (DacData !== DAC_W'(8192)) begin n_bad++; $display("FAIL reset_dac: got %0d, required 8192", DacData); end
    n_cmp++; if (DacValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, required 0", DacValid); end
    n_cmp++; if (SquareOut !== 1'b0) begin n_bad++; $display("FAIL reset_square: got %b, required 0", SquareOut); end
    n_cmp++; if (ZeroCross !== 1'b0) begin n_bad++; $display("FAIL reset_zc: got %b, required 0", ZeroCross); end
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b, required 0", CfgPending); end
    n_cmp++; if (ClipFlag !== 1'b0) begin n_bad++; $display("FAIL reset_clip: got %b, required 0", ClipFlag); end
    RESETn = 1'b1;
  endtask

  task automatic test_amp_offset();
    do_reset();
    send(ONE_Q329, 8192);
    drain("off_mode");
    load(3'd1, 16'h4000, 16'h0000);
    n_cmp++; if (CfgPending !== 1'b1) begin n_bad++; $display("FAIL off_load_pending: got %b, required 1", CfgPending); end
    cycle();
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL off_commit: got %b, required 0", CfgPending); end
    send(32'h1000_0000, 10240);
    drain("amp_half");
    do_reset();
    load(3'd1, 16'h4000, 16'hFED4);
    cycle();
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL offset_commit: got %b, required 0", CfgPending); end
    send(32'h1000_0000, 9940);
    drain("offset");
    n_cmp++; if (ClipFlag !== 1'b0) begin n_bad++; $display("FAIL offset_noclip: got %b, required 0", ClipFlag); end
  endtask

  task automatic test_sine();
    do_reset();
    load(3'd1, 16'h8000, 16'h0000);
    cycle();
    send(ONE_Q329, 16383);
    send(32'h0000_0000, 8192);
    send(32'hE000_0000, 0);
    drain("sine");
    n_cmp++; if (ClipFlag !== 1'b1) begin n_bad++; $display("FAIL sine_clip: got %b, required 1", ClipFlag); end
    ClipClr = 1'b1;
    cycle();
    ClipClr = 1'b0;
    n_cmp++; if (ClipFlag !== 1'b0) begin n_bad++; $display("FAIL clip_clear: got %b, required 0", ClipFlag); end
    send(ONE_Q329, 16383);
    cycle();
    cycle();
    n_cmp++; if (DacValid !== 1'b0) begin n_bad++; $display("FAIL latency_early: DacValid=%b at N+2, required 0", DacValid); end
    ClipClr = 1'b1;
    cycle();
    ClipClr = 1'b0;
    n_cmp++; if (DacValid !== 1'b1) begin n_bad++; $display("FAIL latency: DacValid=%b at N+3, required 1", DacValid); end
    n_cmp++; if (ClipFlag !== 1'b1) begin n_bad++; $display("FAIL clip_set_wins: got %b, required 1", ClipFlag); end
    drain("clip_set");
  endtask

  task automatic test_square();
    logic [31:0] ramp [4];
    logic        sq_exp [4];
    int          dac_exp [4];
    ramp[0] = 32'h0000_0000;  sq_exp[0] = 1'b0; dac_exp[0] = 0;
    ramp[1] = HYST + 32'd1;   sq_exp[1] = 1'b1; dac_exp[1] = 16383;
    ramp[2] = HYST - 32'd1;   sq_exp[2] = 1'b1; dac_exp[2] = 16383;
    ramp[3] = -(HYST + 32'd1); sq_exp[3] = 1'b0; dac_exp[3] = 0;
    do_reset();
    load(MODE_SQUARE, 16'h8000, 16'h0000);
    cycle();
    for (int i = 0; i < 4; i++) begin
      send(ramp[i], dac_exp[i]);
      n_cmp++;
      if (SquareOut !== sq_exp[i]) begin
        n_bad++;
        $display("FAIL square_out[%0d]: got %b, required %b", i, SquareOut, sq_exp[i]);
      end
    end
    drain("square");
  endtask

  task automatic test_commit();
    do_reset();
    load(3'd1, 16'h8000, 16'h0000);
    cycle();
    send(32'h1000_0000, 12288);
    load(3'd1, 16'h2000, 16'h0000);
    n_cmp++; if (CfgPending !== 1'b1) begin n_bad++; $display("FAIL commit_pending: got %b, required 1", CfgPending); end
    send(32'h1000_0000, 12288);
    send(32'hF000_0000, 4096);
    Sample = 32'h0800_0000;
    Enable = 1'b0;
    cycle();
    n_cmp++; if (ZeroCross !== 1'b0) begin n_bad++; $display("FAIL zc_needs_enable: got %b, required 0", ZeroCross); end
    n_cmp++; if (CfgPending !== 1'b1) begin n_bad++; $display("FAIL commit_waits: got %b, required 1", CfgPending); end
    send(32'h0800_0000, 10240);
    n_cmp++; if (ZeroCross !== 1'b1) begin n_bad++; $display("FAIL zc_pulse: got %b, required 1", ZeroCross); end
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL commit_done: got %b, required 0", CfgPending); end
    send(32'h0800_0000, 8704);
    n_cmp++; if (ZeroCross !== 1'b0) begin n_bad++; $display("FAIL zc_one_cycle: got %b, required 0", ZeroCross); end
    drain("commit");
  endtask

  task automatic test_last_wins();
    load(3'd1, 16'h1000, 16'h0000);
    load(3'd1, 16'h3000, 16'h0000);
    send(32'hF000_0000, 7168);
    send(32'h1000_0000, 9216);
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL last_wins_commit: got %b, required 0", CfgPending); end
    send(32'h1000_0000, 9728);
    drain("last_wins");
  endtask

  task automatic test_load_at_commit();
    send(32'hF000_0000, 6656);
    load(3'd1, 16'h1000, 16'h0000);
    CfgMode   = 3'd1;
    CfgAmp    = 16'h8000;
    CfgOffset = 16'h0000;
    CfgLoad   = 1'b1;
    Sample    = 32'h1000_0000;
    Enable    = 1'b1;
    exp_q.push_back(9728);
    cycle();
    CfgLoad   = 1'b0;
    Enable    = 1'b0;
    n_cmp++; if (ZeroCross !== 1'b1) begin n_bad++; $display("FAIL coincident_zc: got %b, required 1", ZeroCross); end
    n_cmp++; if (CfgPending !== 1'b1) begin n_bad++; $display("FAIL coincident_pending: got %b, required 1", CfgPending); end
    send(32'h1000_0000, 8704);
    send(32'hF000_0000, 7680);
    send(32'h1000_0000, 8704);
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL second_commit: got %b, required 0", CfgPending); end
    send(32'h1000_0000, 12288);
    drain("load_at_commit");
  endtask

  task automatic test_reset_flush();
    logic saw_valid;
    do_reset();
    load(3'd1, 16'h8000, 16'h0000);
    cycle();
    send(ONE_Q329, 16383);
    drain("flush_pre");
    load(3'd1, 16'h1000, 16'h0000);
    send(ONE_Q329, 16383);
    send(ONE_Q329, 16383);
    RESETn = 1'b0;
    cycle();
    RESETn = 1'b1;
    exp_q.delete();
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (DacValid === 1'b1) saw_valid = 1'b1;
      cycle();
    end
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: saw DacValid=%b, required 0", saw_valid); end
    n_cmp++; if (DacData !== DAC_W'(8192)) begin n_bad++; $display("FAIL flush_dac: got %0d, required 8192", DacData); end
    n_cmp++; if (SquareOut !== 1'b0) begin n_bad++; $display("FAIL flush_square: got %b, required 0", SquareOut); end
    n_cmp++; if (CfgPending !== 1'b0) begin n_bad++; $display("FAIL flush_pending: got %b, required 0", CfgPending); end
    n_cmp++; if (ClipFlag !== 1'b0) begin n_bad++; $display("FAIL flush_clip: got %b, required 0", ClipFlag); end
  endtask

  initial begin
    test_reset();
    test_amp_offset();
    test_sine();
    test_square();
    test_commit();
    test_last_wins();
    test_load_at_commit();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
